// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

   localparam int ARB_DW    = 16;
   localparam int ARB_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } arb_state_t;

   // Choice made from IDLE; on a tie the master that was not granted last wins.
   function automatic arb_state_t arb_pick(input logic last, input logic cyc0, input logic cyc1);
      arb_state_t pick;
      pick = IDLE;
      if (cyc0 && cyc1) begin
         pick = last ? G0 : G1;
      end else if (cyc0) begin
         pick = G0;
      end else if (cyc1) begin
         pick = G1;
      end
      return pick;
   endfunction

endpackage

// File: rtl/bus_arbiter2_if.sv
// Wishbone-style point-to-point link; one instance per master port and one for the slave port.
interface bus_arbiter2_if #(
   parameter int AW = 7
);
   import bus_arb_pkg::*;

   logic              cyc;
   logic              stb;
   logic              we;
   logic [AW:1]       adr;
   logic [ARB_DW-1:0] dat_w;
   logic [1:0]        sel;
   logic              ack;
   logic              err;
   logic [ARB_DW-1:0] dat_r;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  ack, err, dat_r
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output ack, err, dat_r
   );

endinterface

// File: rtl/bus_arb_wdog.sv
// Stall watchdog for the shared slave port; only built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arb_wdog
   import bus_arb_pkg::*;
#(
   parameter int TO_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic stb_i,
   input  logic ack_i,
   input  logic gnt_chg_i,
   output logic err_o
);

   localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(TO_CYCLES - 1);

   logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

   assign err_o = stb_i & ~ack_i & (cnt_q == CNT_LAST);

   // The abort itself also clears, so a master that ignores err sees a fresh full timeout.
   always_comb begin
      cnt_d = cnt_q + ARB_CNT_W'(1);
      if (gnt_chg_i || !stb_i || ack_i || err_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter for one shared 16-bit slave; grant locked for the whole cycle.
// Optional slave-stall watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no grant, all slave-side outputs 0
//   G0    | master 0 owns the slave port
//   G1    | master 1 owns the slave port
module bus_arbiter2
   import bus_arb_pkg::*;
#(
   parameter int AW        = 7,
   parameter int TO_CYCLES = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   bus_arbiter2_if.slave  m0,
   bus_arbiter2_if.slave  m1,
   bus_arbiter2_if.master s
);

   if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to
      $error("bus_arbiter2: TO_CYCLES must lie in 2..255");
   end

   arb_state_t state_q, state_d;
   logic       last_q, last_d;
   logic       wd_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: state_d = arb_pick(last_q, m0.cyc, m1.cyc);
         G0: begin
            if (!m0.cyc) begin
               state_d = m1.cyc ? G1 : IDLE;
            end
         end
         G1: begin
            if (!m1.cyc) begin
               state_d = m0.cyc ? G0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == G0) begin
         last_d = 1'b0;
      end else if (state_d == G1) begin
         last_d = 1'b1;
      end
   end

   // Muxing is purely combinational from the registered grant: zero added latency per beat.
   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      s.adr    = '0;
      s.dat_w  = '0;
      s.sel    = '0;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m0.dat_r = '0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m1.dat_r = '0;
      unique case (state_q)
         G0: begin
            s.cyc    = m0.cyc;
            s.stb    = m0.stb;
            s.we     = m0.we;
            s.adr    = m0.adr;
            s.dat_w  = m0.dat_w;
            s.sel    = m0.sel;
            m0.ack   = s.ack & ~wd_err;
            m0.err   = wd_err;
            m0.dat_r = s.dat_r;
         end
         G1: begin
            s.cyc    = m1.cyc;
            s.stb    = m1.stb;
            s.we     = m1.we;
            s.adr    = m1.adr;
            s.dat_w  = m1.dat_w;
            s.sel    = m1.sel;
            m1.ack   = s.ack & ~wd_err;
            m1.err   = wd_err;
            m1.dat_r = s.dat_r;
         end
         default: ;
      endcase
   end

`ifdef BUS_ARB_TIMEOUT_EN
   logic gnt_chg;

   assign gnt_chg = (state_d != state_q);

   bus_arb_wdog #(
      .TO_CYCLES (TO_CYCLES)
   ) u_wdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .stb_i     (s.stb),
      .ack_i     (s.ack),
      .gnt_chg_i (gnt_chg),
      .err_o     (wd_err)
   );
`else
   assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: directed scenarios plus a random phase against a grant-ownership model.
module tb_bus_arbiter2;
   import bus_arb_pkg::*;

   localparam int AW    = 7;
   localparam int TO    = 4;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_ni = 1'b1;
   always #5 clk = ~clk;

   bus_arbiter2_if #(.AW(AW)) m0_bus ();
   bus_arbiter2_if #(.AW(AW)) m1_bus ();
   bus_arbiter2_if #(.AW(AW)) s_bus ();

   bus_arbiter2 #(.AW(AW), .TO_CYCLES(TO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .m0     (m0_bus),
      .m1     (m1_bus),
      .s      (s_bus)
   );

   // master drive variables, index = master number
   logic        mc [2];
   logic        ms [2];
   logic        mw [2];
   logic [AW:1] ma [2];
   logic [15:0] md [2];
   logic [1:0]  msel [2];

   assign m0_bus.cyc = mc[0];  assign m0_bus.stb = ms[0];  assign m0_bus.we = mw[0];
   assign m0_bus.adr = ma[0];  assign m0_bus.dat_w = md[0]; assign m0_bus.sel = msel[0];
   assign m1_bus.cyc = mc[1];  assign m1_bus.stb = ms[1];  assign m1_bus.we = mw[1];
   assign m1_bus.adr = ma[1];  assign m1_bus.dat_w = md[1]; assign m1_bus.sel = msel[1];

   // slave model: memory with combinational ack
   logic [15:0] mem [DEPTH];
   logic        ack_en;
   assign s_bus.ack   = s_bus.stb & ack_en;
   assign s_bus.dat_r = mem[s_bus.adr];
   assign s_bus.err   = 1'b0;

   int checks = 0;
   int failures = 0;

   // reference model: which master owns the slave, who was granted last, stall length
   int   owner, last, stall;
   logic e_stb_q, e_err_q;
   logic ack_seen [2];
   logic err_seen [2];

   int          beat_src [$];
   logic [AW:1] beat_adr [$];
   logic [15:0] beat_dat [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      for (int i = 0; i < 2; i++) begin
         mc[i] = 1'b0; ms[i] = 1'b0; mw[i] = 1'b0;
         ma[i] = '0; md[i] = '0; msel[i] = 2'b11;
      end
   endtask

   task automatic check_outputs();
      logic        e_cyc, e_stb, e_we, e_err;
      logic [AW:1] e_adr;
      logic [15:0] e_dw;
      logic [1:0]  e_sel;
      logic        e_ack [2];
      logic        e_er [2];
      logic [15:0] e_dr [2];
      int          o;
      o = owner;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dw = '0; e_sel = '0;
      if (o >= 0) begin
         e_cyc = mc[o]; e_stb = ms[o]; e_we = mw[o];
         e_adr = ma[o]; e_dw = md[o]; e_sel = msel[o];
      end
`ifdef BUS_ARB_TIMEOUT_EN
      e_err = (o >= 0) && e_stb && !ack_en && (stall == TO - 1);
`else
      e_err = 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
         e_ack[i] = (o == i) && e_stb && ack_en && !e_err;
         e_er[i]  = (o == i) && e_err;
         e_dr[i]  = (o == i) ? mem[ma[i]] : 16'h0;
      end
      chk("s_ctrl", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel}, {e_cyc, e_stb, e_we, e_sel});
      chk("s_adr", s_bus.adr, e_adr);
      chk("s_dat", s_bus.dat_w, e_dw);
      chk("m0_ack", m0_bus.ack, e_ack[0]);
      chk("m1_ack", m1_bus.ack, e_ack[1]);
      chk("m0_err", m0_bus.err, e_er[0]);
      chk("m1_err", m1_bus.err, e_er[1]);
      chk("m0_dat", m0_bus.dat_r, e_dr[0]);
      chk("m1_dat", m1_bus.dat_r, e_dr[1]);
      ack_seen[0] = m0_bus.ack; ack_seen[1] = m1_bus.ack;
      err_seen[0] = m0_bus.err; err_seen[1] = m1_bus.err;
      if (s_bus.cyc && s_bus.stb && s_bus.ack) begin
         beat_src.push_back(m0_bus.ack ? 0 : (m1_bus.ack ? 1 : 2));
         beat_adr.push_back(s_bus.adr);
         beat_dat.push_back(s_bus.dat_w);
         if (s_bus.we) begin
            if (s_bus.sel[0]) mem[s_bus.adr][7:0]  = s_bus.dat_w[7:0];
            if (s_bus.sel[1]) mem[s_bus.adr][15:8] = s_bus.dat_w[15:8];
         end
      end
      e_stb_q = e_stb;
      e_err_q = e_err;
   endtask

   // Ownership rule: keep while cyc held, otherwise hand to the preferred requester.
   task automatic model_step();
      int o, pref, n;
      o = owner;
      pref = 1 - ((o >= 0) ? o : last);
      if (o >= 0 && mc[o]) n = o;
      else if (mc[pref]) n = pref;
      else if (mc[1 - pref]) n = 1 - pref;
      else n = -1;
      if (e_err_q || n != o || !(e_stb_q && !ack_en)) stall = 0;
      else stall++;
      if (n >= 0) last = n;
      owner = n;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      owner = -1; last = 1; stall = 0;
      #1;
      check_outputs();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      set_idle();
      rst_ni = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          bcnt [2];
      int          errs, err_at;
      logic [15:0] wd [4];

      for (int k = 0; k < DEPTH; k++) mem[k] = 16'($urandom);
      mem[2] = 16'h01B7;
      set_idle();
      ack_en = 1'b1;
      #2;
      do_reset();

      // single master read of address 2
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 7'd2;
      cycle();
      #1;
      chk("rd_ack", m0_bus.ack, 1);
      chk("rd_dat", m0_bus.dat_r, 16'h01B7);
      chk("rd_m1_ack", m1_bus.ack, 0);
      cycle();
      set_idle();
      cycle(); cycle();

      // tie straight after reset: m0 first, then m1 without an idle gap
      do_reset();
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 7'd10;
      mc[1] = 1'b1; ms[1] = 1'b1; ma[1] = 7'd20;
      cycle();
      #1;
      chk("tie_first_adr", s_bus.adr, 10);
      chk("tie_first_ack0", m0_bus.ack, 1);
      cycle();
      mc[0] = 1'b0; ms[0] = 1'b0;
      cycle();
      #1;
      chk("tie_handover_cyc", s_bus.cyc, 1);
      chk("tie_handover_adr", s_bus.adr, 20);
      chk("tie_handover_ack1", m1_bus.ack, 1);
      set_idle();
      cycle(); cycle();

      // fairness: both request continuously with 2-beat bursts
      do_reset();
      beat_src.delete(); beat_adr.delete(); beat_dat.delete();
      bcnt[0] = 0; bcnt[1] = 0;
      mc[0] = 1'b1; ms[0] = 1'b1; mc[1] = 1'b1; ms[1] = 1'b1;
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < 2; i++) ma[i] = 7'($urandom);
         cycle();
         for (int i = 0; i < 2; i++) begin
            if (!mc[i]) begin
               mc[i] = 1'b1; ms[i] = 1'b1;
            end else if (ack_seen[i]) begin
               bcnt[i]++;
               if (bcnt[i] == 2) begin
                  bcnt[i] = 0; mc[i] = 1'b0; ms[i] = 1'b0;
               end
            end
         end
      end
      chk("fair_nbeats", beat_src.size() >= 8, 1);
      for (int k = 0; k < 8; k++) begin
         if (beat_src.size() > k) chk("fair_order", beat_src[k], (k / 2) % 2);
      end
      set_idle();
      cycle(); cycle();

      // locked 4-beat write burst from m1 while m0 waits
      beat_src.delete(); beat_adr.delete(); beat_dat.delete();
      for (int k = 0; k < 4; k++) wd[k] = 16'($urandom);
      mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b1; msel[1] = 2'b11; ma[1] = 7'd4; md[1] = wd[0];
      cycle();
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 7'd9;
      for (int k = 0; k < 4; k++) begin
         ma[1] = 7'(4 + k); md[1] = wd[k];
         cycle();
         chk("lock_m0_noack", ack_seen[0], 0);
      end
      mc[1] = 1'b0; ms[1] = 1'b0; mw[1] = 1'b0;
      cycle();
      chk("lock_m0_noack_drop", ack_seen[0], 0);
      cycle();
      chk("lock_m0_after", ack_seen[0], 1);
      chk("lock_nbeats", beat_src.size(), 5);
      for (int k = 0; k < 4; k++) begin
         if (beat_src.size() > k) begin
            chk("lock_src", beat_src[k], 1);
            chk("lock_adr", beat_adr[k], 4 + k);
            chk("lock_dat", beat_dat[k], wd[k]);
         end
         chk("lock_mem", mem[4 + k], wd[k]);
      end
      set_idle();
      cycle(); cycle();

      // watchdog: slave never acks
      ack_en = 1'b0;
      errs = 0; err_at = -1;
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 7'd3;
      for (int t = 0; t < 10; t++) begin
         cycle();
         if (err_seen[0]) begin
            errs++;
            if (err_at < 0) err_at = t;
            mc[0] = 1'b0; ms[0] = 1'b0;
         end
      end
`ifdef BUS_ARB_TIMEOUT_EN
      chk("wd_pulses", errs, 1);
      chk("wd_when", err_at, 4);
`else
      chk("wd_pulses", errs, 0);
`endif
      set_idle();
      ack_en = 1'b1;
      cycle(); cycle();

      // random traffic against the ownership model
      do_reset();
      for (int t = 0; t < 300; t++) begin
         ack_en = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            if (mc[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  mc[i] = 1'b0; ms[i] = 1'b0;
               end else begin
                  ms[i] = 1'($urandom);
               end
            end else if ($urandom_range(0, 1) == 1) begin
               mc[i] = 1'b1; ms[i] = 1'($urandom);
            end
            mw[i] = 1'($urandom); ma[i] = 7'($urandom);
            md[i] = 16'($urandom); msel[i] = 2'($urandom);
         end
         cycle();
      end
      set_idle();
      ack_en = 1'b1;
      cycle(); cycle();

      // reset in the middle of a granted m0 burst
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 7'd5;
      cycle(); cycle();
      #2;
      chk("pre_rst_stb", s_bus.stb, 1);
      rst_ni = 1'b0;
      #1;
      chk("rst_async_cyc", s_bus.cyc, 0);
      chk("rst_async_stb", s_bus.stb, 0);
      chk("rst_async_adr", s_bus.adr, 0);
      chk("rst_async_ack", m0_bus.ack, 0);
      chk("rst_async_dat", m0_bus.dat_r, 0);
      do_reset();
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 7'd11;
      mc[1] = 1'b1; ms[1] = 1'b1; ma[1] = 7'd22;
      cycle();
      #1;
      chk("post_rst_tie", s_bus.adr, 11);
      set_idle();
      cycle(); cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
